// File: rtl/inst_fetch_unit.sv
// Fetch stage and PC sequencer: one instruction in flight, fetched over a req/ack
// handshake, held for the decoder, and retired into a new PC chosen by jump/branch.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  Jump,
   input  logic        Branch,
   input  logic        zero,
   input  logic [31:0] reg_target,
   input  logic        retire,
   output logic        align_err,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] pc_r;
   logic [31:0] inst_r;
   logic [31:0] cnt_r;
   logic        align_err_r;
   logic [31:0] next_pc_s;
   logic [31:0] br_off_s;
   logic        align_set_s;
   logic        do_ack_s;
   logic        do_retire_s;

   // Handshake sequencing; ack and retire only count in their own state.
   always_comb begin
      state_s     = state_r;
      do_ack_s    = 1'b0;
      do_retire_s = 1'b0;
      case (state_r)
         S_IDLE: state_s = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               state_s  = S_EXEC;
               do_ack_s = 1'b1;
            end else begin
               state_s = S_REQ;
            end
         end
         S_EXEC: begin
            if (retire) begin
               state_s     = S_REQ;
               do_retire_s = 1'b1;
            end else begin
               state_s = S_EXEC;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Next-PC selection: jump beats branch, Jump==3 falls through to sequential.
   always_comb begin
      br_off_s    = {{14{inst_r[15]}}, inst_r[15:0], 2'b00};
      align_set_s = 1'b0;
      if (Jump == 2'd1) begin
         next_pc_s = {pc_plus4[31:28], inst_r[25:0], 2'b00};
      end else if (Jump == 2'd2) begin
         next_pc_s   = {reg_target[31:2], 2'b00};
         align_set_s = |reg_target[1:0];
      end else if (Branch && zero) begin
         next_pc_s = pc_plus4 + br_off_s;
      end else begin
         next_pc_s = pc_plus4;
      end
   end

   // State, PC, instruction latch, retire counter and alignment pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         pc_r        <= RESET_PC;
         inst_r      <= 32'h0000_0000;
         cnt_r       <= 32'h0000_0000;
         align_err_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         align_err_r <= do_retire_s & align_set_s;
         if (do_ack_s) begin
            inst_r <= imem_rdata;
         end
         if (do_retire_s) begin
            pc_r  <= next_pc_s;
            cnt_r <= cnt_r + 32'd1;
         end
      end
   end

   assign imem_req    = (state_r == S_REQ);
   assign inst_valid  = (state_r == S_EXEC);
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign pc_plus4    = pc_r + 32'd4;
   assign inst        = inst_r;
   assign align_err   = align_err_r;
   assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a table of fetch/retire records with
// hand-computed next PCs, plus hand sequences for reset during REQ/EXEC.
module tb_inst_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  Jump;
   logic        Branch;
   logic        zero;
   logic [31:0] reg_target;
   logic        retire;
   logic        align_err;
   logic [31:0] retired_cnt;

   int checks;
   int failures;
   int exp_cnt;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      logic [1:0]  jump;
      logic        br;
      logic        zr;
      logic [31:0] regt;
      logic [31:0] nxt;
      logic        al;
      int          req_wait;
      int          exec_wait;
   } vec_t;

   vec_t vecs[14];

   inst_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_valid(inst_valid),
      .pc(pc), .pc_plus4(pc_plus4),
      .Jump(Jump), .Branch(Branch), .zero(zero),
      .reg_target(reg_target), .retire(retire),
      .align_err(align_err), .retired_cnt(retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [31:0] addr, logic [31:0] word, logic [1:0] jump,
                               logic br, logic zr, logic [31:0] regt, logic [31:0] nxt,
                               logic al, int req_wait, int exec_wait);
      vec_t v;
      v.addr = addr; v.word = word; v.jump = jump; v.br = br; v.zr = zr;
      v.regt = regt; v.nxt = nxt; v.al = al; v.req_wait = req_wait; v.exec_wait = exec_wait;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("req_wait_timeout", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, v.addr);
      // retire while fetching must be ignored; address must stay put
      for (int i = 0; i < v.req_wait; i++) begin
         retire = 1'b1;
         step();
         chk("req_hold", {31'd0, imem_req}, 32'd1);
         chk("addr_stable", imem_addr, v.addr);
         chk("cnt_no_retire_in_req", retired_cnt, exp_cnt);
      end
      retire     = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = v.word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("inst_latched", inst, v.word);
      chk("inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("req_low_exec", {31'd0, imem_req}, 32'd0);
      chk("pc_plus4", pc_plus4, v.addr + 32'd4);
      // a stray ack while executing must not overwrite the instruction
      for (int i = 0; i < v.exec_wait; i++) begin
         imem_ack = 1'b1;
         step();
         chk("inst_stable_exec", inst, v.word);
         chk("valid_hold", {31'd0, inst_valid}, 32'd1);
      end
      imem_ack   = 1'b0;
      Jump       = v.jump;
      Branch     = v.br;
      zero       = v.zr;
      reg_target = v.regt;
      retire     = 1'b1;
      step();
      retire     = 1'b0;
      Jump       = 2'd0;
      Branch     = 1'b0;
      zero       = 1'b0;
      reg_target = 32'h0;
      exp_cnt++;
      chk("next_pc", pc, v.nxt);
      chk("next_addr", imem_addr, v.nxt);
      chk("align_err", {31'd0, align_err}, {31'd0, v.al});
      chk("retired_cnt", retired_cnt, exp_cnt);
      chk("valid_low_after_retire", {31'd0, inst_valid}, 32'd0);
      step();
      chk("align_err_pulse_end", {31'd0, align_err}, 32'd0);
   endtask

   initial begin
      checks = 0; failures = 0; exp_cnt = 0;
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; retire = 1'b0;
      Jump = 2'd0; Branch = 1'b0; zero = 1'b0; reg_target = 32'h0;

      vecs[0]  = mk(32'h0000_3000, 32'h2408_0001, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3004, 1'b0, 3, 0);
      vecs[1]  = mk(32'h0000_3004, 32'h0000_0020, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3008, 1'b0, 0, 0);
      vecs[2]  = mk(32'h0000_3008, 32'h1000_FFFE, 2'd0, 1'b1, 1'b1, 32'h0,         32'h0000_3004, 1'b0, 0, 2);
      vecs[3]  = mk(32'h0000_3004, 32'h0800_0C00, 2'd1, 1'b1, 1'b1, 32'h0,         32'h0000_3000, 1'b0, 1, 0);
      vecs[4]  = mk(32'h0000_3000, 32'h0000_0008, 2'd2, 1'b0, 1'b0, 32'h0000_3013, 32'h0000_3010, 1'b1, 0, 0);
      vecs[5]  = mk(32'h0000_3010, 32'h1000_0003, 2'd0, 1'b1, 1'b1, 32'h0,         32'h0000_3020, 1'b0, 0, 1);
      vecs[6]  = mk(32'h0000_3020, 32'h1000_FFFE, 2'd0, 1'b1, 1'b0, 32'h0,         32'h0000_3024, 1'b0, 0, 0);
      vecs[7]  = mk(32'h0000_3024, 32'h0BFF_FFFF, 2'd3, 1'b0, 1'b0, 32'h0,         32'h0000_3028, 1'b0, 0, 0);
      vecs[8]  = mk(32'h0000_3028, 32'h0000_0008, 2'd2, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 0, 0);
      vecs[9]  = mk(32'hFFFF_FFFC, 32'h0000_0020, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 0, 0);
      vecs[10] = mk(32'h0000_0000, 32'h0BFF_FFFF, 2'd1, 1'b0, 1'b0, 32'h0,         32'h0FFF_FFFC, 1'b0, 0, 0);
      vecs[11] = mk(32'h0FFF_FFFC, 32'h0800_0001, 2'd1, 1'b0, 1'b0, 32'h0,         32'h1000_0004, 1'b0, 0, 0);
      vecs[12] = mk(32'h1000_0004, 32'h0000_0009, 2'd2, 1'b0, 1'b0, 32'h0000_3002, 32'h0000_3000, 1'b1, 2, 0);
      vecs[13] = mk(32'h0000_3000, 32'h1000_FFFE, 2'd0, 1'b0, 1'b1, 32'h0,         32'h0000_3004, 1'b0, 0, 0);

      step();
      step();
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_inst", inst, 32'h0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_cnt", retired_cnt, 32'h0);
      chk("rst_align", {31'd0, align_err}, 32'd0);
      rst = 1'b0;
      step();
      chk("idle_to_req", {31'd0, imem_req}, 32'd1);

      for (int k = 0; k < 14; k++) begin
         run_vec(vecs[k]);
      end

      // reset while a fetch is pending, with an ack arriving in the reset cycle
      chk("pending_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      rst = 1'b0; imem_ack = 1'b0;
      exp_cnt = 0;
      chk("mid_rst_pc", pc, 32'h0000_3000);
      chk("mid_rst_inst", inst, 32'h0);
      chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_cnt", retired_cnt, 32'h0);
      step();
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("refetch_addr", imem_addr, 32'h0000_3000);

      // reset while executing, with retire and a jump asserted
      imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
      step();
      imem_ack = 1'b0;
      chk("exec_before_rst", {31'd0, inst_valid}, 32'd1);
      rst = 1'b1; retire = 1'b1; Jump = 2'd2; reg_target = 32'h0000_4001;
      step();
      rst = 1'b0; retire = 1'b0; Jump = 2'd0; reg_target = 32'h0;
      chk("exec_rst_pc", pc, 32'h0000_3000);
      chk("exec_rst_inst", inst, 32'h0);
      chk("exec_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("exec_rst_cnt", retired_cnt, 32'h0);
      chk("exec_rst_align", {31'd0, align_err}, 32'd0);
      // late ack while idle is dropped
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      step();
      imem_ack = 1'b0;
      chk("idle_ack_dropped_inst", inst, 32'h0);
      chk("idle_ack_dropped_valid", {31'd0, inst_valid}, 32'd0);
      chk("idle_ack_req", {31'd0, imem_req}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
